bcd_convert_ctrl: RTL and testbench

BCD_CONVERT_CTRL -- requirements
Module: bcd_convert_ctrl

---
 rtl/bcd_convert_ctrl.sv | 132 +++++++++++++
 tb/tb_bcd_convert_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/bcd_convert_ctrl.sv
// Serial 8-bit binary to 3-digit BCD converter (shift-and-add-3) with registered 7-segment outputs.
// Optional macro BCD_BLANK_LEADING_ZERO_EN blanks leading zeros on HEX2/HEX1.
module bcd_convert_ctrl #(
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        start,
   input  logic [7:0]  bin,
   output logic        busy,
   output logic        done,
   output logic [11:0] bcd,
   output logic [6:0]  HEX2,
   output logic [6:0]  HEX1,
   output logic [6:0]  HEX0
);

   // Patterns are tabulated active-low; XOR flips them for active-high boards.
   localparam logic [6:0] SEG_POL = (SEG_ACTIVE_LOW != 0) ? 7'h00 : 7'h7F;
   localparam logic [6:0] SEG_BLANK = 7'h7F ^ SEG_POL;
   localparam logic [6:0] SEG_ZERO  = 7'h40 ^ SEG_POL;
`ifdef BCD_BLANK_LEADING_ZERO_EN
   localparam logic [6:0] SEG_LEAD_RST = SEG_BLANK;
`else
   localparam logic [6:0] SEG_LEAD_RST = SEG_ZERO;
`endif

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0: p = 7'h40;
         4'd1: p = 7'h79;
         4'd2: p = 7'h24;
         4'd3: p = 7'h30;
         4'd4: p = 7'h19;
         4'd5: p = 7'h12;
         4'd6: p = 7'h02;
         4'd7: p = 7'h78;
         4'd8: p = 7'h00;
         4'd9: p = 7'h10;
         default: p = 7'h7F;
      endcase
      return p ^ SEG_POL;
   endfunction

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t      state_q, state_d;
   logic [3:0]  count_q, count_d;
   logic [11:0] scratch_q, scratch_d;
   logic [7:0]  sr_q, sr_d;
   logic [11:0] bcd_q, bcd_d;
   logic [6:0]  hex2_q, hex2_d, hex1_q, hex1_d, hex0_q, hex0_d;
   logic [11:0] adj;

   always_comb begin
      adj = scratch_q;
      for (int i = 0; i < 3; i++)
         if (scratch_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      scratch_d = scratch_q;
      sr_d      = sr_q;
      bcd_d     = bcd_q;
      hex2_d    = hex2_q;
      hex1_d    = hex1_q;
      hex0_d    = hex0_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               sr_d      = bin;
               scratch_d = '0;
               count_d   = '0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            // Eight shifts on count 0..7; count 8 is the hand-off cycle into DONE.
            if (count_q == 4'd8) begin
               bcd_d  = scratch_q;
               hex0_d = seg7(scratch_q[3:0]);
`ifdef BCD_BLANK_LEADING_ZERO_EN
               hex2_d = (scratch_q[11:8] == 4'd0) ? SEG_BLANK : seg7(scratch_q[11:8]);
               hex1_d = (scratch_q[11:4] == 8'd0) ? SEG_BLANK : seg7(scratch_q[7:4]);
`else
               hex2_d = seg7(scratch_q[11:8]);
               hex1_d = seg7(scratch_q[7:4]);
`endif
               state_d = DONE;
            end else begin
               {scratch_d, sr_d} = {adj, sr_q} << 1;
               count_d = count_q + 4'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q   <= IDLE;
         count_q   <= '0;
         scratch_q <= '0;
         sr_q      <= '0;
         bcd_q     <= '0;
         hex2_q    <= SEG_LEAD_RST;
         hex1_q    <= SEG_LEAD_RST;
         hex0_q    <= SEG_ZERO;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         scratch_q <= scratch_d;
         sr_q      <= sr_d;
         bcd_q     <= bcd_d;
         hex2_q    <= hex2_d;
         hex1_q    <= hex1_d;
         hex0_q    <= hex0_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign bcd  = bcd_q;
   assign HEX2 = hex2_q;
   assign HEX1 = hex1_q;
   assign HEX0 = hex0_q;

endmodule

// File: tb/tb_bcd_convert_ctrl.sv
// Directed self-checking bench for bcd_convert_ctrl: timing, segment patterns, start/reset
// interaction and an exhaustive 0..255 sweep against a decimal model.
module tb_bcd_convert_ctrl;

   logic        Clock = 1'b0;
   logic        Reset, start;
   logic [7:0]  bin;
   logic        busy, done;
   logic [11:0] bcd;
   logic [6:0]  HEX2, HEX1, HEX0;

   int n_chk = 0;
   int n_err = 0;

`ifdef BCD_BLANK_LEADING_ZERO_EN
   localparam logic [6:0] ZLEAD = 7'h7F;
`else
   localparam logic [6:0] ZLEAD = 7'h40;
`endif

   bcd_convert_ctrl dut (
      .Clock(Clock), .Reset(Reset), .start(start), .bin(bin),
      .busy(busy), .done(done), .bcd(bcd),
      .HEX2(HEX2), .HEX1(HEX1), .HEX0(HEX0)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   function automatic logic [11:0] dec3(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // Start at edge N, scramble bin during the conversion, check N+1..N+10.
   task automatic convert(input logic [7:0] v, input logic [11:0] eb, input bit hx,
                          input logic [6:0] e2, input logic [6:0] e1, input logic [6:0] e0);
      bin = v; start = 1'b1;
      tick();
      start = 1'b0; bin = ~v;
      for (int i = 1; i <= 8; i++) begin
         tick();
         chk("busy_shift", 32'(busy), 32'd1);
         chk("done_early", 32'(done), 32'd0);
      end
      tick();
      chk("done_pulse", 32'(done), 32'd1);
      chk("bcd", 32'(bcd), 32'(eb));
      chk("nib0_le9", 32'(bcd[3:0] <= 4'd9), 32'd1);
      chk("nib1_le9", 32'(bcd[7:4] <= 4'd9), 32'd1);
      if (hx) begin
         chk("HEX2", 32'(HEX2), 32'(e2));
         chk("HEX1", 32'(HEX1), 32'(e1));
         chk("HEX0", 32'(HEX0), 32'(e0));
      end
      tick();
      chk("done_off", 32'(done), 32'd0);
      chk("busy_off", 32'(busy), 32'd0);
      chk("bcd_hold", 32'(bcd), 32'(eb));
   endtask

   logic [7:0] vals [0:32];

   initial begin
      Reset = 1'b1; start = 1'b0; bin = 8'h00;
      tick(); tick();
      Reset = 1'b0;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_bcd", 32'(bcd), 32'h000);
      chk("rst_HEX0", 32'(HEX0), 32'h40);
      chk("rst_HEX1", 32'(HEX1), 32'(ZLEAD));
      chk("rst_HEX2", 32'(HEX2), 32'(ZLEAD));

      convert(8'd255, 12'h255, 1'b1, 7'h24, 7'h12, 7'h12);
      convert(8'd9,   12'h009, 1'b1, ZLEAD, ZLEAD, 7'h10);
      convert(8'd100, 12'h100, 1'b1, 7'h79, 7'h40, 7'h40);
      convert(8'd0,   12'h000, 1'b1, ZLEAD, ZLEAD, 7'h40);
      convert(8'd45,  12'h045, 1'b1, ZLEAD, 7'h19, 7'h12);
      convert(8'd207, 12'h207, 1'b1, 7'h24, 7'h40, 7'h78);
      convert(8'd63,  12'h063, 1'b1, ZLEAD, 7'h02, 7'h30);

      // start held high, bin moving every cycle: acceptances at k = 0, 11, 22.
      for (int k = 0; k <= 32; k++) begin
         vals[k] = 8'(8'd17 + 7 * k);
         bin = vals[k]; start = 1'b1;
         tick();
         chk("held_busy", 32'(busy), 32'((k % 11) != 10));
         chk("held_done", 32'(done), 32'((k % 11) == 9));
         if ((k % 11) == 9) chk("held_bcd", 32'(bcd), 32'(dec3(int'(vals[k - 9]))));
      end
      start = 1'b0;
      tick();
      chk("held_idle", 32'(busy), 32'd0);

      // Reset on the 4th shift edge aborts the conversion.
      bin = 8'd200; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_bcd", 32'(bcd), 32'h000);
      chk("abort_HEX0", 32'(HEX0), 32'h40);
      chk("abort_HEX1", 32'(HEX1), 32'(ZLEAD));
      chk("abort_HEX2", 32'(HEX2), 32'(ZLEAD));
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("abort_nodone", 32'(done), 32'd0);
      end

      // Reset wins over a simultaneous start.
      convert(8'd77, 12'h077, 1'b0, 7'h00, 7'h00, 7'h00);
      Reset = 1'b1; start = 1'b1; bin = 8'd88;
      tick();
      Reset = 1'b0; start = 1'b0;
      chk("prio_busy", 32'(busy), 32'd0);
      chk("prio_bcd", 32'(bcd), 32'h000);
      for (int i = 0; i < 11; i++) begin
         tick();
         chk("prio_nodone", 32'(done), 32'd0);
      end

      for (int v = 0; v < 256; v++)
         convert(8'(v), dec3(v), 1'b0, 7'h00, 7'h00, 7'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
